regunit_sequencer: RTL

Command-driven controller directly upstream of the 8-bit register unit. It queues (mode, data, read) commands, then drives the unit's `mode_input`, `output_control` and shared `io_bus` with correct one-cycle op pulses and bus turnaround. On request it captures the unit's result from `io_bus` and returns it as a response. It is the only other driver on `io_bus`.

---
 rtl/regseq_pkg.sv | 38 +++
 rtl/regseq_fifo.sv | 55 +++++
 rtl/regunit_sequencer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/regseq_pkg.sv
// regseq_pkg: mode codes, FSM states and the queued command record shared by
// the register-unit sequencer and its command FIFO.
// Build option: REGSEQ_REPEAT_EN adds a 4-bit repeat count to every command.
package regseq_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHR  = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_GUP  = 3'b011;
    localparam logic [2:0] MODE_GDN  = 3'b100;
    localparam logic [2:0] MODE_NOT  = 3'b101;
    localparam logic [2:0] MODE_SWAP = 3'b110;
    localparam logic [2:0] MODE_LOAD = 3'b111;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

`ifdef REGSEQ_REPEAT_EN
    typedef struct packed {
        logic [2:0]       mode;
        logic [7:0]       data;
        logic             read;
        logic [CNT_W-1:0] count;
    } cmd_t;
`else
    typedef struct packed {
        logic [2:0] mode;
        logic [7:0] data;
        logic       read;
    } cmd_t;
`endif

endpackage

// File: rtl/regseq_fifo.sv
// regseq_fifo: first-word fall-through command queue. Full/empty come from a
// registered occupancy counter one bit wider than the pointers.
module regseq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 12
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == OCC_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd_ptr];

    // Storage write; contents need no reset since occupancy gates every read.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-2 depth).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/regunit_sequencer.sv
// regunit_sequencer: queues (mode, data, read) commands and plays them into the
// 8-bit register unit, owning the shared io_bus during load ISSUE cycles only.
// Build option: REGSEQ_REPEAT_EN adds cmd_count (ISSUE held count+1 cycles).
//
// state | meaning
// IDLE  | hold mode to unit, bus released; pop next command when queue non-empty
// ISSUE | present command mode; drive io_bus with load data when mode is LOAD
// READ  | hold mode, unit owns io_bus; capture its output at the closing edge
module regunit_sequencer import regseq_pkg::*; #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_mode,
    input  logic [7:0] cmd_data,
    input  logic       cmd_read,
`ifdef REGSEQ_REPEAT_EN
    input  logic [3:0] cmd_count,
`endif
    output logic [2:0] mode_input,
    output logic       output_control,
    inout  wire  [7:0] io_bus,
    output logic       rsp_valid,
    output logic [7:0] rsp_data
);

    state_t     r_state;
    state_t     w_state_next;
    cmd_t       r_cmd;
    cmd_t       w_fifo_din;
    cmd_t       w_fifo_dout;
    logic       w_full;
    logic       w_empty;
    logic       w_pop;
    logic       w_repeat_done;
    logic       w_bus_oe;
    logic       r_rsp_valid;
    logic [7:0] r_rsp_data;

`ifdef REGSEQ_REPEAT_EN
    logic [CNT_W-1:0] r_repeat;

    assign w_fifo_din    = '{mode: cmd_mode, data: cmd_data, read: cmd_read, count: cmd_count};
    assign w_repeat_done = (r_repeat == '0);

    // Remaining repeats: loaded on pop, counted down while ISSUE is extended.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                        r_repeat <= '0;
        else if (w_pop)                                    r_repeat <= w_fifo_dout.count;
        else if (r_state == ST_ISSUE && !w_repeat_done)    r_repeat <= r_repeat - 1'b1;
    end
`else
    assign w_fifo_din    = '{mode: cmd_mode, data: cmd_data, read: cmd_read};
    assign w_repeat_done = 1'b1;
`endif

    assign cmd_ready = !w_full;
    assign w_pop     = (r_state == ST_IDLE) && !w_empty;

    regseq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(cmd_t))
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_push  (cmd_valid),
        .i_data  (w_fifo_din),
        .i_pop   (w_pop),
        .o_data  (w_fifo_dout),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state decode; READ must directly follow the last ISSUE cycle so a
    // Gray result is sampled before the hold mode overwrites it.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (!w_empty) w_state_next = ST_ISSUE;
            ST_ISSUE: if (w_repeat_done) w_state_next = r_cmd.read ? ST_READ : ST_IDLE;
            ST_READ:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Output decode from registered state; bus driver and output_control are
    // tied to disjoint states so they can never overlap.
    always_comb begin
        mode_input     = MODE_HOLD;
        output_control = 1'b0;
        w_bus_oe       = 1'b0;
        case (r_state)
            ST_ISSUE: begin
                mode_input = r_cmd.mode;
                w_bus_oe   = (r_cmd.mode == MODE_LOAD);
            end
            ST_READ:  output_control = 1'b1;
            default:  ;
        endcase
    end

    assign io_bus = w_bus_oe ? r_cmd.data : 8'hzz;

    // Command register, loaded from the FIFO head on pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     r_cmd <= '0;
        else if (w_pop) r_cmd <= w_fifo_dout;
    end

    // Response capture at the edge closing READ; pulse valid for one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= (r_state == ST_READ);
            if (r_state == ST_READ) r_rsp_data <= io_bus;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;

endmodule
